// File: rtl/encoder_pkg.sv
// Shared types, default widths and the delta saturation helper for the
// encoder speed measurement block.
package encoder_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } meas_state_e;

  localparam int DEF_SPEED_W  = 24;
  localparam int DEF_AVG_LOG2 = 2;

  // Clamp a 32-bit signed value into the range of a signed 'width'-bit word.
  function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] value,
                                                      input int                 width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/encoder_speed_meas_if.sv
// Position-in / speed-out bundle between the decoder side and the speed loop.
interface encoder_speed_meas_if import encoder_pkg::*; #(
  parameter int SPEED_W = DEF_SPEED_W
);
  logic [31:0]               I_Decode_data;
  logic                      I_clr;
  logic signed [SPEED_W-1:0] O_Speed_data;
  logic                      O_Speed_valid;
  logic                      O_Dir;
  logic                      O_Sat;

  modport master (
    output I_Decode_data,
    output I_clr,
    input  O_Speed_data,
    input  O_Speed_valid,
    input  O_Dir,
    input  O_Sat
  );

  modport slave (
    input  I_Decode_data,
    input  I_clr,
    output O_Speed_data,
    output O_Speed_valid,
    output O_Dir,
    output O_Sat
  );
endinterface

// File: rtl/speed_avg_ring.sv
// Moving average over the last 2^AVG_LOG2 deltas, kept as a running sum.
// avg_o only changes (with a one-cycle avg_vld_o) once the ring is full.
module speed_avg_ring import encoder_pkg::*; #(
  parameter int SPEED_W  = DEF_SPEED_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      wr_i,
  input  logic signed [SPEED_W-1:0] delta_i,
  output logic signed [SPEED_W-1:0] avg_o,
  output logic                      avg_vld_o,
  output logic                      filled_o
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = SPEED_W + AVG_LOG2;

  logic signed [SPEED_W-1:0] slot_q [DEPTH];
  logic [DEPTH-1:0]          slot_wr;
  logic [AVG_LOG2-1:0]       wr_ptr_q;
  logic                      filled_q;
  logic                      filled_d;
  logic signed [SUM_W-1:0]   sum_q;
  logic signed [SUM_W-1:0]   sum_d;
  logic signed [SUM_W-1:0]   new_ext;
  logic signed [SUM_W-1:0]   old_ext;
  logic signed [SPEED_W-1:0] oldest;
  logic signed [SPEED_W-1:0] avg_q;
  logic                      avg_vld_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_wr
    assign slot_wr[gi] = wr_i && (wr_ptr_q == AVG_LOG2'(gi));
  end

  // The write pointer always points at the oldest entry, which is replaced.
  assign oldest   = slot_q[wr_ptr_q];
  assign new_ext  = {{AVG_LOG2{delta_i[SPEED_W-1]}}, delta_i};
  assign old_ext  = {{AVG_LOG2{oldest[SPEED_W-1]}}, oldest};
  assign sum_d    = sum_q + new_ext - old_ext;
  assign filled_d = filled_q || (wr_i && (wr_ptr_q == AVG_LOG2'(DEPTH - 1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      wr_ptr_q  <= '0;
      filled_q  <= 1'b0;
      sum_q     <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      wr_ptr_q  <= '0;
      filled_q  <= 1'b0;
      sum_q     <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_wr[i]) slot_q[i] <= delta_i;
      end
      avg_vld_q <= wr_i && filled_d;
      if (wr_i) begin
        wr_ptr_q <= wr_ptr_q + AVG_LOG2'(1);
        sum_q    <= sum_d;
        filled_q <= filled_d;
        // Taking the upper bits is an arithmetic shift: rounds toward -inf.
        if (filled_d) avg_q <= sum_d[SUM_W-1:AVG_LOG2];
      end
    end
  end

  assign avg_o     = avg_q;
  assign avg_vld_o = avg_vld_q;
  assign filled_o  = filled_q;

endmodule

// File: rtl/encoder_speed_meas.sv
// Per-window speed from a free-running 32-bit position count: wrap-safe
// delta, saturation to SPEED_W, moving average, one strobe per window.
module encoder_speed_meas import encoder_pkg::*; #(
  parameter int SAMPLE_CYCLES = 100000,
  parameter int AVG_LOG2      = DEF_AVG_LOG2,
  parameter int SPEED_W       = DEF_SPEED_W
) (
  input  logic               I_sys_clk,
  input  logic               I_sys_rst,
  encoder_speed_meas_if.slave meas
);
  localparam int PRESC_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  logic [1:0]                rst_sync_q;
  logic                      rst_n;
  logic [PRESC_W-1:0]        presc_q;
  logic [PRESC_W-1:0]        presc_d;
  logic                      tick;
  meas_state_e               state_q;
  meas_state_e               state_d;
  logic [31:0]               sample_q;
  logic [31:0]               prev_q;
  logic                      s1_vld_q;
  logic                      s1_use_q;
  logic signed [31:0]        diff_s;
  logic signed [31:0]        diff_sat;
  logic                      clamp;
  logic signed [SPEED_W-1:0] delta_q;
  logic                      s2_vld_q;
  logic                      sat_q;
  logic signed [SPEED_W-1:0] ring_avg;
  logic                      ring_vld;
  logic                      ring_filled;

  // Assert asynchronously, release two clocks later in the clk domain.
  always_ff @(posedge I_sys_clk or negedge I_sys_rst) begin
    if (!I_sys_rst) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign tick = (presc_q == PRESC_W'(SAMPLE_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    unique case (state_q)
      ST_INIT: if (tick) state_d = ST_FILL;
      ST_FILL: if (ring_filled) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
    if (meas.I_clr) begin
      state_d = ST_INIT;
      presc_d = '0;
    end
  end

  always_ff @(posedge I_sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  // Modulo-2^32 difference read as signed makes counter rollover invisible.
  assign diff_s   = $signed(sample_q - prev_q);
  assign diff_sat = sat_to_width(diff_s, SPEED_W);
  assign clamp    = (diff_sat != diff_s);

  always_ff @(posedge I_sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      prev_q   <= '0;
      s1_vld_q <= 1'b0;
      s1_use_q <= 1'b0;
      delta_q  <= '0;
      s2_vld_q <= 1'b0;
      sat_q    <= 1'b0;
    end else if (meas.I_clr) begin
      sample_q <= '0;
      prev_q   <= '0;
      s1_vld_q <= 1'b0;
      s1_use_q <= 1'b0;
      delta_q  <= '0;
      s2_vld_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      if (tick) sample_q <= meas.I_Decode_data;
      s1_vld_q <= tick;
      // The INIT tick only seeds prev_q; it carries no delta downstream.
      s1_use_q <= (state_q != ST_INIT);
      if (s1_vld_q) prev_q <= sample_q;
      s2_vld_q <= s1_vld_q && s1_use_q;
      if (s1_vld_q && s1_use_q) begin
        delta_q <= diff_sat[SPEED_W-1:0];
        if (clamp) sat_q <= 1'b1;
      end
    end
  end

  speed_avg_ring #(
    .SPEED_W  (SPEED_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_ring (
    .clk_i     (I_sys_clk),
    .rst_ni    (rst_n),
    .clr_i     (meas.I_clr),
    .wr_i      (s2_vld_q),
    .delta_i   (delta_q),
    .avg_o     (ring_avg),
    .avg_vld_o (ring_vld),
    .filled_o  (ring_filled)
  );

  assign meas.O_Speed_data  = ring_avg;
  assign meas.O_Speed_valid = ring_vld;
  assign meas.O_Dir         = ~ring_avg[SPEED_W-1];
  assign meas.O_Sat         = sat_q;

endmodule
